seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver_if.sv | 12 +
 rtl/seg7_scan_driver.sv | 102 ++++++++++
 tb/tb_seg7_scan_driver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: the RAM word and enable in, the scanned segment/anode pins and frame strobe out.
// Combinational wiring only; no backpressure.
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic        enable;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  modport master (output value, enable, input seg, an, frame_done);
  modport slave  (input value, enable, output seg, an, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// Scans a 16-bit word onto a 4-digit multiplexed 7-segment display, one hex nibble per digit.
// Latency: outputs are registered, 1 cycle. No backpressure: the scan is free-running and value is sampled once per frame.
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter bit SEG_ACT_LO = 1'b1,
  parameter bit AN_ACT_LO  = 1'b1,
  parameter bit BLANK_LZ   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACT_LO ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = AN_ACT_LO  ? 4'hF  : 4'h0;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic          first;
  logic          frame_done_q;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;

  logic          presc_wrap;
  logic          load;
  logic [3:0]    nib;
  logic          upper_zero;
  logic          blank;
  logic [6:0]    seg_hi;
  logic [3:0]    an_hi;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_nxt;

  assign presc_wrap = (presc == PW'(SCAN_DIV - 1));
  // The first edge after reset reloads too, so a fresh value shows without waiting a whole frame.
  assign load       = first || (presc_wrap && (idx == 2'd3));

  always_comb begin
    nib        = shadow[3:0];
    upper_zero = 1'b0;
    case (idx)
      2'd0: begin nib = shadow[3:0];   upper_zero = 1'b0;                  end
      2'd1: begin nib = shadow[7:4];   upper_zero = (shadow[15:4]  == '0); end
      2'd2: begin nib = shadow[11:8];  upper_zero = (shadow[15:8]  == '0); end
      default: begin nib = shadow[15:12]; upper_zero = (shadow[15:12] == '0); end
    endcase
  end

  always_comb begin
    seg_hi = 7'h00;
    case (nib)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      default: seg_hi = 7'h71;
    endcase
  end

  always_comb begin
    blank   = !bus.enable || (BLANK_LZ && upper_zero);
    an_hi   = blank ? 4'h0 : (4'h1 << idx);
    seg_nxt = blank ? SEG_OFF : (SEG_ACT_LO ? ~seg_hi : seg_hi);
    an_nxt  = AN_ACT_LO ? ~an_hi : an_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= 2'd0;
      shadow       <= 16'h0;
      first        <= 1'b1;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      presc        <= presc_wrap ? '0 : presc + 1'b1;
      if (presc_wrap) idx <= idx + 2'd1;
      if (load) shadow <= bus.value;
      first        <= 1'b0;
      frame_done_q <= load;
      seg_q        <= seg_nxt;
      an_q         <= an_nxt;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Three instances (active-low, active-high, leading-zero blanking) against a scoreboard fed by a spec-level scan model.
module tb_seg7_scan_driver;
  localparam int DIV = 4;
  localparam logic [6:0] SEG_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam bit SLO [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit ALO [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit BLZ [3] = '{1'b0, 1'b0, 1'b1};

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        enable;

  seg7_scan_driver_if if0 ();
  seg7_scan_driver_if if1 ();
  seg7_scan_driver_if if2 ();
  assign if0.value = value;  assign if0.enable = enable;
  assign if1.value = value;  assign if1.enable = enable;
  assign if2.value = value;  assign if2.enable = enable;

  seg7_scan_driver #(.SCAN_DIV(DIV), .SEG_ACT_LO(1'b1), .AN_ACT_LO(1'b1), .BLANK_LZ(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  seg7_scan_driver #(.SCAN_DIV(DIV), .SEG_ACT_LO(1'b0), .AN_ACT_LO(1'b0), .BLANK_LZ(1'b0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  seg7_scan_driver #(.SCAN_DIV(DIV), .SEG_ACT_LO(1'b1), .AN_ACT_LO(1'b1), .BLANK_LZ(1'b1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  wire [11:0] obs0 = {if0.frame_done, if0.an, if0.seg};
  wire [11:0] obs1 = {if1.frame_done, if1.an, if1.seg};
  wire [11:0] obs2 = {if2.frame_done, if2.an, if2.seg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;
  logic [11:0] sb_q [$];

  int          m_presc;
  logic [1:0]  m_idx;
  logic [15:0] m_shadow;
  logic        m_first;

  task automatic chk_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs(input int k);
    case (k)
      0: return obs0;
      1: return obs1;
      default: return obs2;
    endcase
  endfunction

  function automatic logic [11:0] rst_word(input int k);
    logic [3:0] a;
    logic [6:0] s;
    a = ALO[k] ? 4'hF : 4'h0;
    s = SLO[k] ? 7'h7F : 7'h00;
    return {1'b0, a, s};
  endfunction

  // {an, seg} the display should show for digit i of word sh under instance k's options
  function automatic logic [10:0] disp(input int k, input logic [1:0] i, input logic [15:0] sh, input logic en);
    logic [15:0] t;
    logic        blank;
    logic [6:0]  s;
    logic [3:0]  a;
    t     = sh >> (4 * i);
    blank = !en || (BLZ[k] && (i != 2'd0) && (t == 16'h0));
    s     = blank ? 7'h00 : SEG_TBL[t[3:0]];
    a     = blank ? 4'h0 : (4'h1 << i);
    if (SLO[k]) s = ~s;
    if (ALO[k]) a = ~a;
    return {a, s};
  endfunction

  task automatic model_reset();
    m_presc  = 0;
    m_idx    = 2'd0;
    m_shadow = 16'h0;
    m_first  = 1'b1;
  endtask

  task automatic step();
    logic        ld;
    logic [11:0] e;
    ld = m_first || (m_presc == DIV - 1 && m_idx == 2'd3);
    for (int k = 0; k < 3; k++) sb_q.push_back({ld, disp(k, m_idx, m_shadow, enable)});
    if (ld) m_shadow = value;
    m_first = 1'b0;
    if (m_presc == DIV - 1) begin
      m_presc = 0;
      m_idx   = m_idx + 2'd1;
    end else begin
      m_presc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      e = sb_q.pop_front();
      chk_eq($sformatf("dut%0d_cyc%0d", k, cyc), obs(k), e);
    end
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    rst_n  = 1'b1;
    value  = 16'h1234;
    enable = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk_eq($sformatf("reset_dut%0d", k), obs(k), rst_word(k));
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk_eq($sformatf("reset_hold_dut%0d", k), obs(k), rst_word(k));
    rst_n = 1'b1;

    // first frame 1234, change mid-frame, next frame shows ABCD
    run(8);
    value = 16'hABCD;
    run(8 + 16);

    // every nibble value through the decoder, both polarities
    value = 16'h3210; run(16);
    value = 16'h7654; run(16);
    value = 16'hBA98; run(16);
    value = 16'hFEDC; run(16);

    // leading-zero blanking
    value = 16'h0005; run(16);
    value = 16'h0000; run(16);
    value = 16'h0340; run(16);
    value = 16'h1234; run(16);

    // display disabled for a frame, then re-enabled mid-digit
    enable = 1'b0; run(18);
    enable = 1'b1; run(8);

    // reset mid digit 2
    value = 16'h5A6B;
    for (int j = 0; j < 64 && !(m_idx == 2'd2 && m_presc == 1); j++) step();
    chk_eq("reach_digit2", {10'h0, m_idx}, 12'h002);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk_eq($sformatf("midreset_dut%0d", k), obs(k), rst_word(k));
    model_reset();
    value = 16'hC0DE;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk_eq($sformatf("midreset_hold_dut%0d", k), obs(k), rst_word(k));
    rst_n = 1'b1;
    run(20);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
